// File: rtl/h2f_avmm_arbiter.sv
// ---------------------------------------------------------------------------
// h2f_avmm_arbiter
//
// Purpose:
//   Two-master round-robin arbiter in front of the 64-bit Avalon-MM register
//   bank reached from the HPS h2f bridge. Master 0 is the HPS bridge and
//   master 1 is a fabric-side master such as a DMA or control FSM. Exactly
//   one transaction is in flight on the slave at any time. Every transaction
//   has a cycle budget, so a slave that never answers cannot lock up either
//   master.
//
// Parameters:
//   ADDRWIDTH       address width on every port
//   DATAWIDTH       data width; byteenable width is DATAWIDTH/8
//   TIMEOUT_CYCLES  cycles allowed in XFER+RDWAIT before abort (>= 2)
//
// Ports:
//   clk, rst                 single clock; asynchronous active-high reset
//   i_mX_read / i_mX_write   X=0,1 requests, held until waitrequest is low
//   i_mX_address             request address
//   i_mX_writedata           write data
//   i_mX_byteenable          byte lanes
//   o_mX_readdata            read data (slave data while X owns the bus, else 0)
//   o_mX_readdatavalid       one-cycle read-return strobe
//   o_mX_waitrequest         low only in the cycle X's request is accepted
//   o_s_read / o_s_write     requests to the slave
//   o_s_address              slave address
//   o_s_writedata            slave write data
//   o_s_byteenable           slave byte lanes
//   i_s_readdata             slave read data
//   i_s_readdatavalid        slave read-return strobe
//   i_s_waitrequest          slave stall
//   o_timeout_err            one-cycle pulse when a transaction is aborted
// ---------------------------------------------------------------------------
module h2f_avmm_arbiter #(
    parameter int ADDRWIDTH      = 10,
    parameter int DATAWIDTH      = 64,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     i_m0_read,
    input  logic                     i_m0_write,
    input  logic [ADDRWIDTH-1:0]     i_m0_address,
    input  logic [DATAWIDTH-1:0]     i_m0_writedata,
    input  logic [DATAWIDTH/8-1:0]   i_m0_byteenable,
    output logic [DATAWIDTH-1:0]     o_m0_readdata,
    output logic                     o_m0_readdatavalid,
    output logic                     o_m0_waitrequest,

    input  logic                     i_m1_read,
    input  logic                     i_m1_write,
    input  logic [ADDRWIDTH-1:0]     i_m1_address,
    input  logic [DATAWIDTH-1:0]     i_m1_writedata,
    input  logic [DATAWIDTH/8-1:0]   i_m1_byteenable,
    output logic [DATAWIDTH-1:0]     o_m1_readdata,
    output logic                     o_m1_readdatavalid,
    output logic                     o_m1_waitrequest,

    output logic                     o_s_read,
    output logic                     o_s_write,
    output logic [ADDRWIDTH-1:0]     o_s_address,
    output logic [DATAWIDTH-1:0]     o_s_writedata,
    output logic [DATAWIDTH/8-1:0]   o_s_byteenable,
    input  logic [DATAWIDTH-1:0]     i_s_readdata,
    input  logic                     i_s_readdatavalid,
    input  logic                     i_s_waitrequest,

    output logic                     o_timeout_err
);

    localparam int BEWIDTH  = DATAWIDTH / 8;
    localparam int CNTWIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNTWIDTH-1:0] CNT_LAST = CNTWIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_XFER   = 2'd1,
        S_RDWAIT = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_grant;
    logic                  r_last_grant;
    logic                  r_op_write;
    logic [CNTWIDTH-1:0]   r_count;

    logic                  w_req0;
    logic                  w_req1;
    logic                  w_pick;
    logic                  w_pick_write;

    logic                  w_g_read;
    logic                  w_g_write;
    logic [ADDRWIDTH-1:0]  w_g_address;
    logic [DATAWIDTH-1:0]  w_g_writedata;
    logic [BEWIDTH-1:0]    w_g_byteenable;

    logic                  w_s_read;
    logic                  w_s_write;
    logic                  w_accept;
    logic                  w_rdv;
    logic                  w_zero_data;
    logic                  w_done;
    logic                  w_abort;
    logic                  w_timeout_hit;
    logic [DATAWIDTH-1:0]  w_owner_data;

    // Round-robin pick: a lone requester wins; on a tie the master that did
    // not finish last goes next.
    assign w_req0       = i_m0_read | i_m0_write;
    assign w_req1       = i_m1_read | i_m1_write;
    assign w_pick       = (w_req0 && w_req1) ? ~r_last_grant : w_req1;
    // Write has priority when a master raises read and write together.
    assign w_pick_write = w_pick ? i_m1_write : i_m0_write;

    // Granted master's request, selected by the registered grant.
    always_comb begin
        w_g_read       = i_m0_read;
        w_g_write      = i_m0_write;
        w_g_address    = i_m0_address;
        w_g_writedata  = i_m0_writedata;
        w_g_byteenable = i_m0_byteenable;
        if (r_grant) begin
            w_g_read       = i_m1_read;
            w_g_write      = i_m1_write;
            w_g_address    = i_m1_address;
            w_g_writedata  = i_m1_writedata;
            w_g_byteenable = i_m1_byteenable;
        end
    end

    assign w_timeout_hit = (r_count == CNT_LAST);

    // Next-state and per-cycle strobes. Completion in the same cycle as the
    // budget running out counts as completion, not as an abort.
    always_comb begin
        w_next_state = r_state;
        w_s_read     = 1'b0;
        w_s_write    = 1'b0;
        w_accept     = 1'b0;
        w_rdv        = 1'b0;
        w_zero_data  = 1'b0;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_req0 || w_req1) begin
                    w_next_state = S_XFER;
                end
            end
            S_XFER: begin
                // The latched op decides the direction; a master dropping its
                // request mid-transfer simply takes the slave request low.
                w_s_write = r_op_write & w_g_write;
                w_s_read  = ~r_op_write & w_g_read;
                if ((w_s_read || w_s_write) && !i_s_waitrequest) begin
                    w_accept = 1'b1;
                    if (r_op_write || i_s_readdatavalid) begin
                        w_done       = 1'b1;
                        w_rdv        = ~r_op_write;
                        w_next_state = S_IDLE;
                    end else begin
                        w_next_state = S_RDWAIT;
                    end
                end
                // An abort also releases the master's waitrequest so a stuck
                // read or write request is let go.
                if (!w_done && w_timeout_hit) begin
                    w_abort      = 1'b1;
                    w_accept     = 1'b1;
                    w_rdv        = ~r_op_write;
                    w_zero_data  = ~r_op_write;
                    w_next_state = S_IDLE;
                end
            end
            S_RDWAIT: begin
                if (i_s_readdatavalid) begin
                    w_done       = 1'b1;
                    w_rdv        = 1'b1;
                    w_next_state = S_IDLE;
                end else if (w_timeout_hit) begin
                    w_abort      = 1'b1;
                    w_rdv        = 1'b1;
                    w_zero_data  = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State, grant and transaction budget.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_op_write   <= 1'b0;
            r_count      <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE) begin
                r_count <= '0;
                if (w_req0 || w_req1) begin
                    r_grant    <= w_pick;
                    r_op_write <= w_pick_write;
                end
            end else begin
                r_count <= r_count + 1'b1;
                if (w_done || w_abort) begin
                    r_last_grant <= r_grant;
                end
            end
        end
    end

    // Slave side.
    assign o_s_read       = w_s_read;
    assign o_s_write      = w_s_write;
    assign o_s_address    = w_g_address;
    assign o_s_writedata  = w_g_writedata;
    assign o_s_byteenable = w_g_byteenable;

    // Master side: an aborted read returns zero data with its strobe.
    assign w_owner_data       = w_zero_data ? '0 : i_s_readdata;
    assign o_m0_waitrequest   = ~(w_accept & ~r_grant);
    assign o_m1_waitrequest   = ~(w_accept &  r_grant);
    assign o_m0_readdatavalid = w_rdv & ~r_grant;
    assign o_m1_readdatavalid = w_rdv &  r_grant;
    assign o_m0_readdata      = ((r_state != S_IDLE) && !r_grant) ? w_owner_data : '0;
    assign o_m1_readdata      = ((r_state != S_IDLE) &&  r_grant) ? w_owner_data : '0;
    assign o_timeout_err      = w_abort;

endmodule

// File: tb/tb_h2f_avmm_arbiter.sv
// ---------------------------------------------------------------------------
// tb_h2f_avmm_arbiter
//
// Purpose:
//   Drives both masters and plays the slave with randomised addresses, data,
//   stall lengths and read latencies. Expected grant order, completion cycle,
//   abort cycle and returned data come from a transaction-level model: a
//   single "last finished owner" bit for round robin and the cycle budget.
// ---------------------------------------------------------------------------
module tb_h2f_avmm_arbiter;

    localparam int AW = 10;
    localparam int DW = 64;
    localparam int BW = DW / 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;

    logic          m0_read, m0_write;
    logic [AW-1:0] m0_address;
    logic [DW-1:0] m0_writedata;
    logic [BW-1:0] m0_byteenable;
    logic [DW-1:0] m0_readdata;
    logic          m0_readdatavalid, m0_waitrequest;

    logic          m1_read, m1_write;
    logic [AW-1:0] m1_address;
    logic [DW-1:0] m1_writedata;
    logic [BW-1:0] m1_byteenable;
    logic [DW-1:0] m1_readdata;
    logic          m1_readdatavalid, m1_waitrequest;

    logic          s_read, s_write;
    logic [AW-1:0] s_address;
    logic [DW-1:0] s_writedata;
    logic [BW-1:0] s_byteenable;
    logic [DW-1:0] s_readdata;
    logic          s_readdatavalid, s_waitrequest;
    logic          timeout_err;

    logic [1:0]    wr;
    logic [1:0]    rdv;
    assign wr  = {m0_waitrequest, m1_waitrequest};
    assign rdv = {m0_readdatavalid, m1_readdatavalid};

    int            compared   = 0;
    int            mismatched = 0;
    logic [255:0]  got, exp;
    bit            rrLast;

    always #5 clk = ~clk;

    h2f_avmm_arbiter #(
        .ADDRWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .i_m0_read(m0_read), .i_m0_write(m0_write), .i_m0_address(m0_address),
        .i_m0_writedata(m0_writedata), .i_m0_byteenable(m0_byteenable),
        .o_m0_readdata(m0_readdata), .o_m0_readdatavalid(m0_readdatavalid),
        .o_m0_waitrequest(m0_waitrequest),
        .i_m1_read(m1_read), .i_m1_write(m1_write), .i_m1_address(m1_address),
        .i_m1_writedata(m1_writedata), .i_m1_byteenable(m1_byteenable),
        .o_m1_readdata(m1_readdata), .o_m1_readdatavalid(m1_readdatavalid),
        .o_m1_waitrequest(m1_waitrequest),
        .o_s_read(s_read), .o_s_write(s_write), .o_s_address(s_address),
        .o_s_writedata(s_writedata), .o_s_byteenable(s_byteenable),
        .i_s_readdata(s_readdata), .i_s_readdatavalid(s_readdatavalid),
        .i_s_waitrequest(s_waitrequest),
        .o_timeout_err(timeout_err)
    );

    // Quiet bus: no requests, slave stalling, junk on slave read data.
    task automatic idle_inputs();
        m0_read = 1'b0; m0_write = 1'b0; m0_address = '0; m0_writedata = '0; m0_byteenable = '0;
        m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_writedata = '0; m1_byteenable = '0;
        s_waitrequest = 1'b1; s_readdatavalid = 1'b0; s_readdata = {$urandom, $urandom};
    endtask

    // Reset values, reset hitting mid-RDWAIT, and m0 winning the first tie.
    task automatic test_reset();
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d;
        int winner;
        idle_inputs();
        m0_read = 1'b1; s_readdatavalid = 1'b1;
        #1 rst = 1'b1;
        @(negedge clk); #1;
        got = 256'({s_read, s_write, wr, rdv, timeout_err, m0_readdata, m1_readdata});
        exp = 256'({7'b0011000, 128'h0});
        compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL reset_values: got %h expected %h", got, exp); end

        @(negedge clk); rst = 1'b0; idle_inputs();
        a0 = AW'($urandom); m0_read = 1'b1; m0_address = a0;
        @(negedge clk); s_waitrequest = 1'b0;
        #1 got = 256'({s_read, s_address, wr}); exp = 256'({1'b1, a0, 2'b01});
        compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL reset_pre_accept: got %h expected %h", got, exp); end

        @(negedge clk); m0_read = 1'b0; m1_read = 1'b1; m1_address = AW'($urandom); s_waitrequest = 1'b1;
        #1 got = 256'({s_read, rdv}); exp = 256'(3'b000);
        compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL reset_rdwait: got %h expected %h", got, exp); end

        d = {$urandom, $urandom};
        #2 rst = 1'b1; s_readdatavalid = 1'b1; s_readdata = d;
        #1 got = 256'({s_read, s_write, wr, rdv, timeout_err, m0_readdata, m1_readdata});
        exp = 256'({7'b0011000, 128'h0});
        compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL reset_mid_rdwait: got %h expected %h", got, exp); end
        rrLast = 1'b1;

        @(negedge clk);
        @(negedge clk); rst = 1'b0; s_readdatavalid = 1'b0;
        a0 = AW'($urandom); a1 = AW'($urandom);
        m0_read = 1'b1; m0_address = a0; m1_read = 1'b1; m1_address = a1;
        #1 got = 256'({s_read, wr}); exp = 256'(3'b011);
        compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL reset_tie_idle: got %h expected %h", got, exp); end

        winner = rrLast ? 0 : 1;
        @(negedge clk); s_waitrequest = 1'b0;
        #1 got = 256'({s_read, s_address, wr});
        exp = 256'({1'b1, (winner == 0) ? a0 : a1, (winner == 0) ? 2'b01 : 2'b10});
        compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL reset_first_tie: got %h expected %h", got, exp); end

        @(negedge clk); m0_read = 1'b0; m1_read = 1'b0; s_waitrequest = 1'b1;
        d = {$urandom, $urandom}; s_readdatavalid = 1'b1; s_readdata = d;
        #1 got = 256'({rdv, m0_readdata, m1_readdata});
        exp = (winner == 0) ? 256'({2'b10, d, 64'h0}) : 256'({2'b01, 64'h0, d});
        compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL reset_tie_data: got %h expected %h", got, exp); end
        rrLast = (winner == 1);
        @(negedge clk); idle_inputs();
    endtask

    // m0 writes, first one fixed, then random back-to-back from the same master.
    task automatic test_write_b2b();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [BW-1:0] be;
        @(negedge clk);
        for (int n = 0; n < 4; n++) begin
            if (n == 0) begin
                a = 10'h008; d = 64'h1122334455667788; be = 8'hFF;
            end else begin
                a = AW'($urandom); d = {$urandom, $urandom}; be = BW'($urandom);
            end
            m0_write = 1'b1; m0_address = a; m0_writedata = d; m0_byteenable = be; s_waitrequest = 1'b1;
            #1 got = 256'({s_write, s_read, wr}); exp = 256'(4'b0011);
            compared++;
            if (got !== exp) begin mismatched++; $display("[TB] FAIL wr_idle_gap: got %h expected %h", got, exp); end
            @(negedge clk); s_waitrequest = 1'b0;
            #1 got = 256'({s_write, s_read, s_address, s_writedata, s_byteenable, wr});
            exp = 256'({2'b10, a, d, be, 2'b01});
            compared++;
            if (got !== exp) begin mismatched++; $display("[TB] FAIL wr_accept: got %h expected %h", got, exp); end
            @(negedge clk);
        end
        rrLast = 1'b0;
        m0_write = 1'b0; s_waitrequest = 1'b1;
        #1 got = 256'({s_write, wr}); exp = 256'(3'b011);
        compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL wr_done: got %h expected %h", got, exp); end
        @(negedge clk); idle_inputs();
    endtask

    // Both masters reading continuously: ownership must alternate.
    task automatic test_round_robin();
        logic [AW-1:0] addr [2];
        logic [DW-1:0] d;
        int owner, w, l;
        addr[0] = AW'($urandom);
        addr[1] = AW'($urandom);
        for (int t = 0; t < 8; t++) begin
            owner = rrLast ? 0 : 1;
            @(negedge clk);
            m0_read = 1'b1; m1_read = 1'b1; m0_address = addr[0]; m1_address = addr[1];
            s_waitrequest = 1'b1; s_readdatavalid = 1'b0;
            #1 got = 256'({s_read, wr}); exp = 256'(3'b011);
            compared++;
            if (got !== exp) begin mismatched++; $display("[TB] FAIL rr_idle: got %h expected %h", got, exp); end
            w = $urandom_range(0, 3);
            l = $urandom_range(0, 3);
            d = {$urandom, $urandom};
            for (int k = 0; k < w; k++) begin
                @(negedge clk);
                #1 got = 256'({s_read, s_address, wr}); exp = 256'({1'b1, addr[owner], 2'b11});
                compared++;
                if (got !== exp) begin mismatched++; $display("[TB] FAIL rr_wait: got %h expected %h", got, exp); end
            end
            @(negedge clk); s_waitrequest = 1'b0;
            if (l == 0) begin s_readdatavalid = 1'b1; s_readdata = d; end
            #1 got = 256'({s_read, s_address, wr});
            exp = 256'({1'b1, addr[owner], (owner == 0) ? 2'b01 : 2'b10});
            compared++;
            if (got !== exp) begin mismatched++; $display("[TB] FAIL rr_accept: got %h expected %h", got, exp); end
            for (int k = 1; k <= l; k++) begin
                @(negedge clk); s_waitrequest = 1'b1;
                s_readdatavalid = (k == l);
                s_readdata = (k == l) ? d : {$urandom, $urandom};
                #1;
                if (k < l) begin
                    got = 256'({s_read, rdv}); exp = 256'(3'b000);
                    compared++;
                    if (got !== exp) begin mismatched++; $display("[TB] FAIL rr_rdwait: got %h expected %h", got, exp); end
                end
            end
            got = 256'({rdv, m0_readdata, m1_readdata});
            exp = (owner == 0) ? 256'({2'b10, d, 64'h0}) : 256'({2'b01, 64'h0, d});
            compared++;
            if (got !== exp) begin mismatched++; $display("[TB] FAIL rr_return: got %h expected %h", got, exp); end
            rrLast = (owner == 1);
            addr[owner] = AW'($urandom);
        end
        @(negedge clk); idle_inputs();
    endtask

    // m1 read with 3 stall cycles and a 2-cycle read latency.
    task automatic test_read_latency();
        logic [AW-1:0] a;
        int pulses;
        pulses = 0;
        a = AW'($urandom);
        @(negedge clk); m1_read = 1'b1; m1_address = a;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); s_waitrequest = 1'b1;
            #1 got = 256'({s_read, s_address, wr}); exp = 256'({1'b1, a, 2'b11});
            compared++;
            if (got !== exp) begin mismatched++; $display("[TB] FAIL lat_wait: got %h expected %h", got, exp); end
        end
        @(negedge clk); s_waitrequest = 1'b0;
        #1 got = 256'({s_read, wr}); exp = 256'(3'b110);
        compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL lat_accept: got %h expected %h", got, exp); end
        @(negedge clk); m1_read = 1'b0; s_waitrequest = 1'b1;
        #1 pulses += int'(m1_readdatavalid);
        got = 256'({s_read, rdv}); exp = 256'(3'b000);
        compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL lat_rdwait: got %h expected %h", got, exp); end
        @(negedge clk); s_readdatavalid = 1'b1; s_readdata = 64'hCAFE;
        #1 pulses += int'(m1_readdatavalid);
        got = 256'({rdv, m1_readdata, m0_readdata}); exp = 256'({2'b01, 64'hCAFE, 64'h0});
        compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL lat_data: got %h expected %h", got, exp); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); s_readdatavalid = (c == 0);
            #1 pulses += int'(m1_readdatavalid);
        end
        compared++;
        if (pulses !== 1) begin mismatched++; $display("[TB] FAIL lat_one_pulse: got %0d expected 1", pulses); end
        rrLast = 1'b1;
        @(negedge clk); idle_inputs();
    endtask

    // m0 read accepted after a random stall, data never returns: abort on
    // cycle TO, then m1 must win the following tie.
    task automatic test_timeout_read();
        logic [AW-1:0] a0, a1, a2;
        logic [DW-1:0] d;
        int wa, winner;
        wa = $urandom_range(0, 4);
        a0 = AW'($urandom); a1 = AW'($urandom); a2 = AW'($urandom);
        @(negedge clk); m0_read = 1'b1; m0_address = a0;
        for (int c = 1; c <= TO; c++) begin
            @(negedge clk);
            s_waitrequest = (c <= wa);
            s_readdata = 64'hDEAD000000000000 | 64'({$urandom});
            m0_read = (c <= wa + 1) || (c >= 12);
            m0_address = (c <= wa + 1) ? a0 : a2;
            if (c >= 8) begin m1_read = 1'b1; m1_address = a1; end
            #1 got = 256'({timeout_err, rdv}); exp = 256'({(c == TO), (c == TO), 1'b0});
            compared++;
            if (got !== exp) begin mismatched++; $display("[TB] FAIL to_rd_cycle%0d: got %h expected %h", c, got, exp); end
            if (c == wa + 1) begin
                got = 256'({s_read, wr}); exp = 256'(3'b101);
                compared++;
                if (got !== exp) begin mismatched++; $display("[TB] FAIL to_rd_accept: got %h expected %h", got, exp); end
            end
            if (c == TO) begin
                got = 256'(m0_readdata); exp = 256'h0;
                compared++;
                if (got !== exp) begin mismatched++; $display("[TB] FAIL to_rd_zero: got %h expected %h", got, exp); end
            end
        end
        rrLast = 1'b0;
        winner = rrLast ? 0 : 1;
        @(negedge clk); s_waitrequest = 1'b1;
        #1 got = 256'({timeout_err, s_read}); exp = 256'(2'b00);
        compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL to_rd_idle: got %h expected %h", got, exp); end
        @(negedge clk); s_waitrequest = 1'b0;
        #1 got = 256'({s_read, s_address, wr});
        exp = 256'({1'b1, (winner == 1) ? a1 : a2, (winner == 0) ? 2'b01 : 2'b10});
        compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL to_rd_next_grant: got %h expected %h", got, exp); end
        @(negedge clk); m0_read = 1'b0; m1_read = 1'b0; s_waitrequest = 1'b1;
        d = {$urandom, $urandom}; s_readdatavalid = 1'b1; s_readdata = d;
        #1 got = 256'({rdv, timeout_err}); exp = 256'({(winner == 0), (winner == 1), 1'b0});
        compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL to_rd_next_done: got %h expected %h", got, exp); end
        rrLast = (winner == 1);
        @(negedge clk); idle_inputs();
    endtask

    // m1 write the slave never accepts: released with waitrequest low on cycle TO.
    task automatic test_timeout_write();
        @(negedge clk);
        m1_write = 1'b1; m1_address = AW'($urandom); m1_writedata = {$urandom, $urandom}; m1_byteenable = 8'hFF;
        for (int c = 1; c <= TO; c++) begin
            @(negedge clk); s_waitrequest = 1'b1;
            #1 got = 256'({timeout_err, s_write, wr, rdv});
            exp = 256'({(c == TO), 1'b1, 1'b1, (c != TO), 2'b00});
            compared++;
            if (got !== exp) begin mismatched++; $display("[TB] FAIL to_wr_cycle%0d: got %h expected %h", c, got, exp); end
        end
        rrLast = 1'b1;
        @(negedge clk); idle_inputs();
    endtask

    // m1 raises read and write together: only the write reaches the slave;
    // a stray slave strobe afterwards is not forwarded.
    task automatic test_read_write_same();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [BW-1:0] be;
        a = 10'h010; d = {$urandom, $urandom}; be = BW'($urandom);
        @(negedge clk);
        m1_read = 1'b1; m1_write = 1'b1; m1_address = a; m1_writedata = d; m1_byteenable = be;
        #1 got = 256'({s_read, s_write}); exp = 256'(2'b00);
        compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL rw_idle: got %h expected %h", got, exp); end
        @(negedge clk);
        #1 got = 256'({s_write, s_read, s_address, wr}); exp = 256'({2'b10, a, 2'b11});
        compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL rw_wait: got %h expected %h", got, exp); end
        @(negedge clk); s_waitrequest = 1'b0;
        #1 got = 256'({s_write, s_read, s_address, s_writedata, s_byteenable, wr});
        exp = 256'({2'b10, a, d, be, 2'b10});
        compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL rw_accept: got %h expected %h", got, exp); end
        rrLast = 1'b1;
        @(negedge clk); m1_read = 1'b0; m1_write = 1'b0; s_waitrequest = 1'b1;
        s_readdatavalid = 1'b1; s_readdata = {$urandom, $urandom};
        #1 got = 256'({rdv, m0_readdata, m1_readdata}); exp = 256'h0;
        compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL rw_late_rdv: got %h expected %h", got, exp); end
        @(negedge clk); s_readdatavalid = 1'b0;
        #1 got = 256'({s_read, s_write, wr}); exp = 256'(4'b0011);
        compared++;
        if (got !== exp) begin mismatched++; $display("[TB] FAIL rw_idle_after: got %h expected %h", got, exp); end
        @(negedge clk); idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write_b2b();
        test_round_robin();
        test_read_latency();
        test_timeout_read();
        test_timeout_write();
        test_read_write_same();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got %0d compared expected completion", compared);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
